// File: rtl/return_addr_stack.sv
// rtl/return_addr_stack.sv - speculative/committed return address stack pair
// The speculative stack is restored from the committed stack's next state on flush.
module return_addr_stack #(
  parameter int DEPTH = 4,
  parameter int ALEN  = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [ALEN-1:0] link_addr_i,
  output logic            valid_o,
  output logic [ALEN-1:0] ret_addr_o,
  input  logic            call_confirm_i,
  input  logic            ret_confirm_i,
  input  logic [ALEN-1:0] res_link_addr_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [ALEN-1:0] s_mem [DEPTH];
  logic [PW-1:0]   s_wp;
  logic [CW-1:0]   s_cnt;
  logic [ALEN-1:0] c_mem [DEPTH];
  logic [PW-1:0]   c_wp;
  logic [CW-1:0]   c_cnt;

  logic [ALEN-1:0] s_mem_n [DEPTH];
  logic [PW-1:0]   s_wp_n;
  logic [CW-1:0]   s_cnt_n;
  logic [ALEN-1:0] c_mem_n [DEPTH];
  logic [PW-1:0]   c_wp_n;
  logic [CW-1:0]   c_cnt_n;

  logic [PW-1:0]   s_top;
  logic [PW-1:0]   c_top;

  assign s_top = s_wp - 1'b1;
  assign c_top = c_wp - 1'b1;

  always_comb begin
    c_mem_n = c_mem;
    c_wp_n  = c_wp;
    c_cnt_n = c_cnt;
    if (call_confirm_i && ret_confirm_i && (c_cnt != '0)) begin
      c_mem_n[c_top] = res_link_addr_i;
    end else if (call_confirm_i) begin
      c_mem_n[c_wp] = res_link_addr_i;
      c_wp_n        = c_wp + 1'b1;
      if (c_cnt != CW'(DEPTH)) c_cnt_n = c_cnt + 1'b1;
    end else if (ret_confirm_i && (c_cnt != '0)) begin
      c_wp_n  = c_top;
      c_cnt_n = c_cnt - 1'b1;
    end
  end

  // On flush the speculative side mirrors the committed side, confirms included.
  always_comb begin
    s_mem_n = s_mem;
    s_wp_n  = s_wp;
    s_cnt_n = s_cnt;
    if (flush_i) begin
      s_mem_n = c_mem_n;
      s_wp_n  = c_wp_n;
      s_cnt_n = c_cnt_n;
    end else if (push_i && pop_i && (s_cnt != '0)) begin
      s_mem_n[s_top] = link_addr_i;
    end else if (push_i) begin
      s_mem_n[s_wp] = link_addr_i;
      s_wp_n        = s_wp + 1'b1;
      if (s_cnt != CW'(DEPTH)) s_cnt_n = s_cnt + 1'b1;
    end else if (pop_i && (s_cnt != '0)) begin
      s_wp_n  = s_top;
      s_cnt_n = s_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        s_mem[i] <= '0;
        c_mem[i] <= '0;
      end
      s_wp  <= '0;
      s_cnt <= '0;
      c_wp  <= '0;
      c_cnt <= '0;
    end else begin
      s_mem <= s_mem_n;
      s_wp  <= s_wp_n;
      s_cnt <= s_cnt_n;
      c_mem <= c_mem_n;
      c_wp  <= c_wp_n;
      c_cnt <= c_cnt_n;
    end
  end

  assign valid_o    = (s_cnt != '0);
  assign ret_addr_o = s_mem[s_top];

endmodule

// File: tb/tb_return_addr_stack.sv
// tb/tb_return_addr_stack.sv - vector table and scoreboard bench for return_addr_stack
module tb_return_addr_stack;

  localparam int DEPTH = 4;
  localparam int ALEN  = 64;

  logic            clk = 1'b0;
  logic            rst, flush, push, pop, call, ret;
  logic [ALEN-1:0] link, res;
  logic            valid;
  logic [ALEN-1:0] ret_addr;

  int assertions = 0;
  int failures   = 0;

  typedef struct {
    logic            rst, flush, push, pop, call, ret;
    logic [ALEN-1:0] link, res;
    logic            ev;
    logic [ALEN-1:0] ea;
    logic            ca;
    string           name;
  } vec_t;

  typedef struct {
    logic            ev;
    logic [ALEN-1:0] ea;
    logic            ca;
    string           name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  return_addr_stack #(.DEPTH(DEPTH), .ALEN(ALEN)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .push_i(push), .pop_i(pop),
    .link_addr_i(link), .valid_o(valid), .ret_addr_o(ret_addr),
    .call_confirm_i(call), .ret_confirm_i(ret), .res_link_addr_i(res)
  );

  function automatic vec_t mk(string name, logic r, logic f, logic pu, logic po,
                              logic [ALEN-1:0] l, logic c, logic rt, logic [ALEN-1:0] rs,
                              logic ev, logic [ALEN-1:0] ea, logic ca);
    vec_t v;
    v.name = name; v.rst = r; v.flush = f; v.push = pu; v.pop = po; v.link = l;
    v.call = c; v.ret = rt; v.res = rs; v.ev = ev; v.ea = ea; v.ca = ca;
    return v;
  endfunction

  task automatic step(input vec_t v);
    exp_t e;
    rst = v.rst; flush = v.flush; push = v.push; pop = v.pop; link = v.link;
    call = v.call; ret = v.ret; res = v.res;
    e.ev = v.ev; e.ea = v.ea; e.ca = v.ca; e.name = v.name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    assertions++;
    if (valid !== e.ev) begin
      failures++;
      $display("FAIL %s valid: got %b expected %b", e.name, valid, e.ev);
    end
    if (e.ca) begin
      assertions++;
      if (ret_addr !== e.ea) begin
        failures++;
        $display("FAIL %s ret_addr: got 0x%0h expected 0x%0h", e.name, ret_addr, e.ea);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; call = 1'b0; ret = 1'b0;
    link = '0; res = '0;

    // name, rst, flush, push, pop, link, call, ret, res, exp_valid, exp_addr, check_addr
    vecs.push_back(mk("reset",       1,0,0,0,'h0,  0,0,'h0,   0,'h0,  1));
    vecs.push_back(mk("pop_empty",   0,0,0,1,'h0,  0,0,'h0,   0,'h0,  1));
    vecs.push_back(mk("push_100",    0,0,1,0,'h100,0,0,'h0,   1,'h100,1));
    vecs.push_back(mk("push_200",    0,0,1,0,'h200,0,0,'h0,   1,'h200,1));
    vecs.push_back(mk("pop_to_100",  0,0,0,1,'h0,  0,0,'h0,   1,'h100,1));
    vecs.push_back(mk("pop_to_empty",0,0,0,1,'h0,  0,0,'h0,   0,'h0,  0));
    vecs.push_back(mk("pop_noop",    0,0,0,1,'h0,  0,0,'h0,   0,'h0,  0));
    vecs.push_back(mk("wrap_10",     0,0,1,0,'h10, 0,0,'h0,   1,'h10, 1));
    vecs.push_back(mk("wrap_20",     0,0,1,0,'h20, 0,0,'h0,   1,'h20, 1));
    vecs.push_back(mk("wrap_30",     0,0,1,0,'h30, 0,0,'h0,   1,'h30, 1));
    vecs.push_back(mk("wrap_40",     0,0,1,0,'h40, 0,0,'h0,   1,'h40, 1));
    vecs.push_back(mk("wrap_50",     0,0,1,0,'h50, 0,0,'h0,   1,'h50, 1));
    vecs.push_back(mk("wrap_pop40",  0,0,0,1,'h0,  0,0,'h0,   1,'h40, 1));
    vecs.push_back(mk("wrap_pop30",  0,0,0,1,'h0,  0,0,'h0,   1,'h30, 1));
    vecs.push_back(mk("wrap_pop20",  0,0,0,1,'h0,  0,0,'h0,   1,'h20, 1));
    vecs.push_back(mk("wrap_pop_e",  0,0,0,1,'h0,  0,0,'h0,   0,'h0,  0));
    vecs.push_back(mk("rep_push",    0,0,1,0,'h100,0,0,'h0,   1,'h100,1));
    vecs.push_back(mk("rep_both",    0,0,1,1,'h300,0,0,'h0,   1,'h300,1));
    vecs.push_back(mk("rep_pop",     0,0,0,1,'h0,  0,0,'h0,   0,'h0,  0));
    vecs.push_back(mk("both_empty",  0,0,1,1,'h700,0,0,'h0,   1,'h700,1));
    vecs.push_back(mk("both_e_pop",  0,0,0,1,'h0,  0,0,'h0,   0,'h0,  0));
    vecs.push_back(mk("reset2",      1,0,0,0,'h0,  0,0,'h0,   0,'h0,  1));
    vecs.push_back(mk("commit_100",  0,0,0,0,'h0,  1,0,'h100, 0,'h0,  1));
    vecs.push_back(mk("spec_100",    0,0,1,0,'h100,0,0,'h0,   1,'h100,1));
    vecs.push_back(mk("spec_500",    0,0,1,0,'h500,0,0,'h0,   1,'h500,1));
    vecs.push_back(mk("flush_rest",  0,1,0,0,'h0,  0,0,'h0,   1,'h100,1));
    vecs.push_back(mk("flush_single",0,0,0,1,'h0,  0,0,'h0,   0,'h0,  0));
    vecs.push_back(mk("flush_call",  0,1,1,0,'h900,1,0,'h400, 1,'h400,1));
    vecs.push_back(mk("fc_pop400",   0,0,0,1,'h0,  0,0,'h0,   1,'h100,1));
    vecs.push_back(mk("fc_pop100",   0,0,0,1,'h0,  0,0,'h0,   0,'h0,  0));
    vecs.push_back(mk("flush_ret",   0,1,0,1,'h0,  0,1,'h0,   1,'h100,1));
    vecs.push_back(mk("fr_pop",      0,0,0,1,'h0,  0,0,'h0,   0,'h0,  0));
    vecs.push_back(mk("rst_prio",    1,1,1,0,'h123,1,0,'h456, 0,'h0,  1));
    vecs.push_back(mk("rst_flush",   0,1,0,0,'h0,  0,0,'h0,   0,'h0,  1));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Committed stack saturation: six confirms into four slots, then restore.
    for (int i = 1; i <= 6; i++)
      step(mk("sat_call", 0,0,0,0,'h0, 1,0,ALEN'(i), 0,'h0, 0));
    step(mk("sat_flush", 0,1,0,0,'h0, 0,0,'h0, 1,'h6, 1));
    step(mk("sat_pop5",  0,0,0,1,'h0, 0,0,'h0, 1,'h5, 1));
    step(mk("sat_pop4",  0,0,0,1,'h0, 0,0,'h0, 1,'h4, 1));
    step(mk("sat_pop3",  0,0,0,1,'h0, 0,0,'h0, 1,'h3, 1));
    step(mk("sat_pop_e", 0,0,0,1,'h0, 0,0,'h0, 0,'h0, 0));

    // Committed stack unaffected by the speculative pops above.
    step(mk("sat_reflush", 0,1,0,0,'h0, 0,1,'h0, 1,'h5, 1));

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    assertions++;

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
